keypad_emulator: RTL

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator_pkg.sv | 26 ++
 rtl/keypad_matrix_drive.sv | 25 ++
 rtl/keypad_emulator.sv | 128 ++++++++++++
 3 files changed

// File: rtl/keypad_emulator_pkg.sv
// rtl/keypad_emulator_pkg.sv - shared types and constants for the keypad emulator
package keypad_emulator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    HOLD   = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_ROW_W   = 2;
  localparam int KEY_COL_LSB = 0;
  localparam int KEY_COL_W   = 2;

  localparam logic [3:0] SWC_IDLE = 4'b1111;

  function automatic logic [1:0] key_row(input logic [3:0] key);
    return key[KEY_ROW_LSB +: KEY_ROW_W];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] key);
    return key[KEY_COL_LSB +: KEY_COL_W];
  endfunction

endpackage

// File: rtl/keypad_matrix_drive.sv
// rtl/keypad_matrix_drive.sv - combinational row-drive to column-sense mapping
// Pulls the key's column low only while the contact is closed and its row is being driven.
module keypad_matrix_drive
  import keypad_emulator_pkg::*;
(
  input  logic [3:0] swr,
  input  logic [3:0] key,
  input  logic       contact,
  output logic [3:0] swc
);

  logic [1:0] row;
  logic [1:0] col;

  always_comb begin
    row = key_row(key);
    col = key_col(key);
    swc = SWC_IDLE;
    // Column 0 sits on the MSB of the sense bus.
    if (contact && !swr[row]) begin
      swc[2'd3 - col] = 1'b0;
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - emulates a bouncing key press on a scanned 4x4 keypad
// Sequencing lives here; the matrix mapping is in keypad_matrix_drive.
module keypad_emulator
  import keypad_emulator_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [7:0] cmd_hold,
  input  logic       SWR0,
  input  logic       SWR1,
  input  logic       SWR2,
  input  logic       SWR3,
  output logic [3:0] SWC,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] BOUNCE_LOAD = 8'(BOUNCE_CYCLES);
  localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYCLES);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] key_q, key_d;
  logic       contact_q, contact_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      hold_q    <= 8'd0;
      key_q     <= 4'd0;
      contact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      key_q     <= key_d;
      contact_q <= contact_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    key_d     = key_q;
    contact_d = contact_q;
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          key_d  = cmd_key;
          hold_d = cmd_hold;
          if (BOUNCE_CYCLES > 0) begin
            state_d   = BOUNCE;
            cnt_d     = BOUNCE_LOAD;
            contact_d = 1'b1;
          end else if (cmd_hold != 8'd0) begin
            state_d   = HOLD;
            cnt_d     = cmd_hold;
            contact_d = 1'b1;
          end else begin
            state_d   = GAP;
            cnt_d     = GAP_LOAD;
            contact_d = 1'b0;
          end
        end
      end
      BOUNCE: begin
        if (cnt_q <= 8'd1) begin
          if (hold_q != 8'd0) begin
            state_d   = HOLD;
            cnt_d     = hold_q;
            contact_d = 1'b1;
          end else begin
            state_d   = GAP;
            cnt_d     = GAP_LOAD;
            contact_d = 1'b0;
          end
        end else begin
          cnt_d     = cnt_q - 8'd1;
          contact_d = ~contact_q;
        end
      end
      HOLD: begin
        if (cnt_q <= 8'd1) begin
          state_d   = GAP;
          cnt_d     = GAP_LOAD;
          contact_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        // done rides the last gap cycle so it never overlaps an acceptance.
        if (cnt_q <= 8'd1) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        contact_d = 1'b0;
      end
    endcase
  end

  keypad_matrix_drive u_matrix (
    .swr     ({SWR3, SWR2, SWR1, SWR0}),
    .key     (key_q),
    .contact (contact_q),
    .swc     (SWC)
  );

endmodule
